// File: rtl/arb_2to1_pkg.sv
// arb_2to1_pkg: shared types and constants for the 2:1 burst arbiter
package arb_2to1_pkg;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;

    localparam int TIMEOUT_DEF = 16;
    localparam int CNT_W       = 8;

endpackage

// File: rtl/mux_2to1.sv
// mux_2to1: two-input data select with enable
//   a, b : candidate inputs (W bits)
//   sel  : 0 picks a, 1 picks b
//   en   : output forced to zero when low
//   y    : selected value
module mux_2to1 #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sel,
    input  logic         en,
    output logic [W-1:0] y
);

    assign y = en ? (sel ? b : a) : '0;

endmodule

// File: rtl/arb_2to1.sv
// arb_2to1: two-requester round-robin burst arbiter with a one-entry output buffer
//   clk, rst                  : clock, synchronous active-high reset
//   reqK_valid/data/last      : requester K beat (K = 0, 1)
//   reqK_ready                : requester K beat accepted this cycle (combinational)
//   out_valid/data/last       : buffered beat toward the shared resource
//   out_ready                 : downstream takes the buffered beat
//   gnt                       : one-hot owner, 2'b00 when idle
//   err                       : one-cycle pulse when the stall watchdog releases an owner
// Optional feature: define ARB_2TO1_WATCHDOG_EN to build the stall watchdog (limit TIMEOUT).
module arb_2to1
    import arb_2to1_pkg::*;
#(
    parameter int n       = 8,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [n-1:0] req0_data,
    input  logic         req0_last,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [n-1:0] req1_data,
    input  logic         req1_last,
    output logic         req1_ready,
    output logic         out_valid,
    output logic [n-1:0] out_data,
    output logic         out_last,
    input  logic         out_ready,
    output logic [1:0]   gnt,
    output logic         err
);

    arb_state_t   state_q, state_d;
    logic         prio_q, prio_d;
    logic         out_valid_q, out_valid_d;
    logic [n-1:0] out_data_q, out_data_d;
    logic         out_last_q, out_last_d;
    logic         out_space, acc;
    logic [n:0]   sel_beat;

    assign gnt        = {state_q == OWN1, state_q == OWN0};
    assign out_space  = !out_valid_q || out_ready;
    assign req0_ready = gnt[0] && out_space;
    assign req1_ready = gnt[1] && out_space;
    assign acc        = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;

    // {last, data} of whichever requester owns the grant
    mux_2to1 #(.W(n + 1)) u_mux (
        .a   ({req0_last, req0_data}),
        .b   ({req1_last, req1_data}),
        .sel (gnt[1]),
        .en  (1'b1),
        .y   (sel_beat)
    );

`ifdef ARB_2TO1_WATCHDOG_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             stall, fire;
    assign err = err_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT;
    assign err        = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (state_q == IDLE) begin
            if (req0_valid && (!req1_valid || !prio_q))
                state_d = OWN0;
            else if (req1_valid)
                state_d = OWN1;
        end else if (acc && sel_beat[n]) begin
            state_d = IDLE;
            prio_d  = (state_q == OWN0);
        end
        if (acc)
            {out_valid_d, out_last_d, out_data_d} = {1'b1, sel_beat};
        else if (out_ready)
            out_valid_d = 1'b0;
`ifdef ARB_2TO1_WATCHDOG_EN
        // a stalled owner never accepts, so the streak also ends on any state change
        stall = (state_q != IDLE) && !(gnt[1] ? req1_valid : req0_valid);
        fire  = stall && (cnt_q == CNT_W'(TIMEOUT - 1));
        cnt_d = (stall && !fire) ? cnt_q + 1'b1 : '0;
        err_d = fire;
        if (fire) begin
            state_d = IDLE;
            prio_d  = (state_q == OWN0);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
`ifdef ARB_2TO1_WATCHDOG_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
`ifdef ARB_2TO1_WATCHDOG_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_arb_2to1.sv
// tb_arb_2to1: randomized and directed bench for arb_2to1 against a behavioural model
module tb_arb_2to1;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req0_last = 1'b0, req1_valid = 1'b0, req1_last = 1'b0;
    logic [7:0] req0_data = '0, req1_data = '0;
    logic       req0_ready, req1_ready;
    logic       out_valid, out_last, err;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic [1:0] gnt;

    arb_2to1 dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .gnt(gnt), .err(err)
    );

    always #5 clk = ~clk;

    // requester beat queues: {last, data}
    logic [8:0] q0[$], q1[$];
    logic [7:0] obs[$];
    logic [1:0] gtrace[$];
    bit en0 = 1, en1 = 1, ordy = 1;
    int n_vec = 0, n_cmp = 0, n_fail = 0;

    // behavioural model: owner index (-1 idle), round-robin pointer, one-slot buffer
    int         m_own = -1;
    bit         m_prio = 0, m_bv = 0, m_bl = 0, m_err = 0;
    logic [7:0] m_bd = '0;
    int         m_stall = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic step(input bit r);
        bit r0, r1, sp, acc, al;
        logic [7:0] ad;
        int old;
        @(negedge clk);
        rst = r;
        req0_valid = en0 && q0.size() > 0;
        {req0_last, req0_data} = req0_valid ? q0[0] : 9'($urandom);
        req1_valid = en1 && q1.size() > 0;
        {req1_last, req1_data} = req1_valid ? q1[0] : 9'($urandom);
        out_ready = ordy;
        #1;
        sp = !m_bv || ordy;
        r0 = m_own == 0 && sp;
        r1 = m_own == 1 && sp;
        chk("req0_ready", req0_ready, r0);
        chk("req1_ready", req1_ready, r1);
        chk("gnt", gnt, m_own < 0 ? 0 : (m_own == 0 ? 1 : 2));
        chk("out_valid", out_valid, m_bv);
        chk("out_data", out_data, m_bd);
        chk("out_last", out_last, m_bl);
        chk("err", err, m_err);
        gtrace.push_back(gnt);
        if (out_valid && out_ready && !r) obs.push_back(out_data);
        n_vec++;
        if (r) begin
            m_own = -1; m_prio = 0; m_bv = 0; m_bd = '0; m_bl = 0; m_err = 0; m_stall = 0;
        end else begin
            acc = (r0 && req0_valid) || (r1 && req1_valid);
            {al, ad} = r1 ? {req1_last, req1_data} : {req0_last, req0_data};
            if (acc) begin
                if (r0) void'(q0.pop_front());
                else    void'(q1.pop_front());
            end
            m_err = 0;
            old = m_own;
            if (acc) begin
                m_bv = 1; m_bd = ad; m_bl = al;
            end else if (ordy) m_bv = 0;
            if (old < 0) begin
                if (req0_valid && req1_valid) m_own = m_prio;
                else if (req0_valid) m_own = 0;
                else if (req1_valid) m_own = 1;
            end else if (acc && al) begin
                m_prio = (old == 0);
                m_own = -1;
            end
`ifdef ARB_2TO1_WATCHDOG_EN
            if (old >= 0 && !(old == 0 ? req0_valid : req1_valid)) begin
                m_stall++;
                if (m_stall == TO) begin
                    m_own = -1; m_prio = (old == 0); m_err = 1; m_stall = 0;
                end
            end else m_stall = 0;
`endif
        end
    endtask

    task automatic drain();
        int k = 0;
        en0 = 1; en1 = 1; ordy = 1;
        do begin
            step(0);
            k++;
        end while ((q0.size() > 0 || q1.size() > 0 || gnt != 0 || out_valid) && k < 60);
        chk("drain_bound", k < 60, 1);
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [7:0] exp4[4];
        logic [1:0] gexp[7];
        logic [1:0] gseq[$];
        logic [1:0] prev;
        int s, e;

        step(1);
        step(1);
        step(0);
        chk("reset_gnt", gnt, 2'b00);
        chk("reset_out_valid", out_valid, 1'b0);

        // both requesters start together right after reset
        obs.delete(); gtrace.delete();
        q0.push_back({1'b0, 8'h11}); q0.push_back({1'b1, 8'h12});
        q1.push_back({1'b0, 8'h21}); q1.push_back({1'b1, 8'h22});
        for (int i = 0; i < 7; i++) step(0);
        gexp = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
        for (int i = 0; i < 7; i++) chk("dual_gnt_trace", gtrace[i], gexp[i]);
        drain();
        exp4 = '{8'h11, 8'h12, 8'h21, 8'h22};
        chk("dual_count", obs.size(), 4);
        for (int i = 0; i < 4 && i < obs.size(); i++) chk("dual_order", obs[i], exp4[i]);

        // single-beat burst
        q0.push_back({1'b1, 8'hA5});
        step(0);
        chk("single_t_gnt", gnt, 2'b00);
        step(0);
        chk("single_t1_ready", req0_ready, 1'b1);
        chk("single_t1_gnt", gnt, 2'b01);
        step(0);
        chk("single_t2_valid", out_valid, 1'b1);
        chk("single_t2_data", out_data, 8'hA5);
        chk("single_t2_last", out_last, 1'b1);
        chk("single_t2_idle", gnt, 2'b00);
        drain();

        // downstream stall mid-burst
        obs.delete();
        for (int i = 0; i < 4; i++) q0.push_back({i == 3, 8'h50 + 8'(i)});
        step(0); step(0); step(0);
        ordy = 0;
        for (int i = 0; i < 4; i++) begin
            step(0);
            chk("stall_ready", req0_ready, 1'b0);
            chk("stall_hold", out_data, 8'h51);
        end
        drain();
        chk("stall_count", obs.size(), 4);
        for (int i = 0; i < 4 && i < obs.size(); i++) chk("stall_order", obs[i], 8'h50 + 8'(i));

        // reset in the middle of a buffered burst
        ordy = 0;
        for (int i = 0; i < 3; i++) q0.push_back({i == 2, 8'h61 + 8'(i)});
        step(0); step(0); step(0);
        chk("midburst_full", out_valid, 1'b1);
        step(1);
        q0.delete();
        step(0);
        chk("midburst_gnt", gnt, 2'b00);
        chk("midburst_valid", out_valid, 1'b0);
        chk("midburst_data", out_data, 8'h00);
        drain();

        // single-beat bursts on both sides must alternate
        gtrace.delete();
        for (int i = 0; i < 6; i++) begin
            q0.push_back({1'b1, 8'h70 + 8'(i)});
            q1.push_back({1'b1, 8'h80 + 8'(i)});
        end
        drain();
        prev = 2'b00;
        foreach (gtrace[i]) begin
            if (gtrace[i] != 0 && prev == 0) gseq.push_back(gtrace[i]);
            prev = gtrace[i];
        end
        chk("alt_grants", gseq.size(), 12);
        for (int i = 1; i < gseq.size(); i++) chk("alt_switch", gseq[i] != gseq[i-1], 1'b1);

`ifdef ARB_2TO1_WATCHDOG_EN
        step(1);
        gtrace.delete();
        q0.push_back({1'b0, 8'h33});
        q1.push_back({1'b1, 8'h44});
        s = -1; e = -1;
        for (int i = 0; i < 40 && e < 0; i++) begin
            step(0);
            if (s < 0 && gnt == 2'b01 && !req0_valid) s = i;
            if (err) e = i;
        end
        chk("wd_fired", e >= 0, 1'b1);
        chk("wd_delay", e - s, TO);
        chk("wd_gnt_idle", gnt, 2'b00);
        step(0);
        chk("wd_err_pulse", err, 1'b0);
        chk("wd_next_owner", gnt, 2'b10);
        drain();
`else
        s = 0; e = 0;
`endif

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            en0 = $urandom_range(0, 3) != 0;
            en1 = $urandom_range(0, 3) != 0;
            ordy = $urandom_range(0, 3) != 0;
            if (q0.size() == 0 && $urandom_range(0, 5) == 0) begin
                int len = $urandom_range(1, 4);
                for (int i = 0; i < len; i++) q0.push_back({i == len - 1, 8'($urandom)});
            end
            if (q1.size() == 0 && $urandom_range(0, 5) == 0) begin
                int len = $urandom_range(1, 4);
                for (int i = 0; i < len; i++) q1.push_back({i == len - 1, 8'($urandom)});
            end
            step($urandom_range(0, 499) == 0);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_2to1.md
# arb_2to1

Two-requester round-robin arbiter that shares one downstream datapath between two sources. Each requester presents an n-bit data stream over a valid/ready handshake, grouped into bursts terminated by a `last` flag. The block locks the grant to one requester for a whole burst, steers that requester's data through a 2:1 data select, and registers the selected beat into a one-entry output buffer. It sits in front of any shared single-port resource (register-file write port, memory port, ALU input) in the catalog.

## Interface
- `n`, 8: data width in bits.
- `TIMEOUT`, 16: stall limit in cycles; used only when the watchdog is compiled in.

- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req0_valid` input 1: requester 0 has a beat.
- `req0_data` input n: requester 0 beat payload.
- `req0_last` input 1: requester 0 beat is the final beat of its burst.
- `req0_ready` output 1: requester 0 beat is accepted this cycle.
- `req1_valid` / `req1_data` / `req1_last` / `req1_ready`: same as above, for requester 1.
- `out_valid` output 1: output buffer holds a beat.
- `out_data` output n: buffered payload.
- `out_last` output 1: buffered beat is the end of a burst.
- `out_ready` input 1: downstream accepts the buffered beat.
- `gnt` output 2: one-hot current owner; 2'b00 when idle.
- `err` output 1: watchdog release pulse; tied to 0 when the watchdog is compiled out.

## Operation
- FSM states: IDLE, OWN0, OWN1.
- Priority bit `prio` resets to 0, which favours requester 0.
- In IDLE:
  - Only reqK_valid high → next state OWNK.
  - Both high → the requester indexed by `prio` wins.
  - Neither high → stay in IDLE.
- In OWNK:
  - reqK_ready = out_space, where out_space = !out_valid | out_ready.
  - The other requester's ready is 0.
  - A beat is accepted when reqK_valid & reqK_ready.
- Acceptance of a beat with reqK_last=1:
  - Next state is IDLE.
  - `prio` becomes the other requester's index, ~K.
- Output buffer:
  - Loads the accepted data and last on acceptance.
  - out_valid clears on out_ready when nothing new is loaded.
  - A simultaneous drain and load keeps out_valid at 1 with the new beat.
- `gnt`: 2'b01 in OWN0, 2'b10 in OWN1, 2'b00 in IDLE.
- A requester dropping valid mid-burst does not release the grant. The owner keeps the grant until it sends `last` (or the watchdog fires).
- Data select uses gnt[1] as select; data flows only through the granted port.

## Timing
- Reset values:
  - state IDLE, prio 0, gnt 0.
  - req0_ready 0, req1_ready 0.
  - out_valid 0, out_data 0, out_last 0, err 0.
  - A beat held in the buffer when reset asserts is discarded.
- Arbitration latency:
  - valid seen in IDLE at cycle t → gnt and ready high at t+1.
  - First beat accepted at t+1 → out_valid high at t+2.
- Throughput:
  - One beat per cycle while out_ready stays high.
  - Each burst end costs one IDLE bubble cycle before the next grant.
- Single-beat burst (valid and last together): one acceptance, then IDLE.
- out_ready low with a full buffer: ready drops to 0 in the same cycle (combinational from out_valid/out_ready); no beat is lost or duplicated.
- Ready paths are combinational from `out_ready`; all other outputs are registered.

## Configuration
- `ARB_2TO1_WATCHDOG_EN` defined:
  - An 8-bit stall counter counts consecutive cycles in OWNK with reqK_valid=0.
  - The counter clears on any acceptance or on a state change.
  - When it reaches TIMEOUT: force the state to IDLE, set `prio` to ~K, and pulse `err` high for exactly one cycle.
  - The buffered beat is kept.
- Not defined: no counter logic; `err` is constant 0; a stalled owner holds the grant indefinitely.

## Structure
- Package `arb_2to1_pkg`:
  - `arb_state_t` enum: IDLE, OWN0, OWN1.
  - TIMEOUT default constant.
  - Counter width constant.
- Sub-module: one `mux_2to1` instance (width n+1, carrying {last, data}) with en tied high and sel = gnt[1], feeding the output buffer.

## Test plan
- Reset in the middle of a 3-beat burst from req0 with out_valid=1 → next cycle: gnt=0, out_valid=0, out_data=0, state IDLE.
- Both requesters raise valid in the same cycle after reset, each with a 2-beat burst (data 0x11,0x12 and 0x21,0x22), out_ready=1 → out_data sequence 0x11, 0x12, 0x21, 0x22; one gnt=0 cycle between the bursts.
- req1 sends back-to-back single-beat bursts while req0 is continuously valid → grants alternate 10, 01, 10…; no starvation.
- out_ready held low for 4 cycles mid-burst → req_ready=0 for those cycles; out_data holds its value; after release, beats resume in order with no loss.
- req0 single beat (valid=1, last=1, data 0xA5) → req0_ready at t+1, out_valid=1 with out_data=0xA5 and out_last=1 at t+2, state IDLE at t+2.
- With ARB_2TO1_WATCHDOG_EN and TIMEOUT=16: req0 sends one non-last beat then holds valid low → err high for one cycle 16 cycles after the stall starts; gnt goes to 0; a pending req1 is granted on the next cycle.
